// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU datapath constants (FSM encoding, opcodes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/serial_add_sub_fac.sv
// ============================================================================
// Module      : FAC
// Description : Single-bit full-adder cell, chained to form the adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module FAC (
  input  logic x,
  input  logic y,
  input  logic c_in,
  output logic z,
  output logic c_out
);

  assign z     = x ^ y ^ c_in;
  assign c_out = (x & y) | (c_in & (x ^ y));

endmodule : FAC

`default_nettype wire

// File: rtl/serial_add_sub.sv
// ============================================================================
// Module      : serial_add_sub
// Description : Multi-cycle W-bit adder/subtractor, K bits per clock, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_sub
  import alu_pkg::*;
#(
  parameter int W = 8,
  parameter int K = 1
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] z,
  output logic         carry,
  output logic         ovf,
  output logic         zero,
  output logic         neg
);

  localparam int N  = W / K;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(N - 1);

  logic [1:0]    r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_acc;
  logic          r_cin;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_z;
  logic          r_carry;
  logic          r_ovf;
  logic          r_zero;
  logic          r_neg;

  logic [K:0]    w_c;
  logic [K-1:0]  w_sum;
  logic [W-1:0]  w_acc_nxt;
  logic          w_last;

  assign w_c[0] = r_cin;

  for (genvar i = 0; i < K; i++) begin : g_cell
    FAC u_fac (
      .x     (r_a[i]),
      .y     (r_b[i]),
      .c_in  (w_c[i]),
      .z     (w_sum[i]),
      .c_out (w_c[i+1])
    );
  end

  // Sum bits enter the result register from the top, so after N chunks
  // the first (LSB) chunk has travelled down to bit 0.
  if (K == W) begin : g_full
    assign w_acc_nxt = w_sum;
  end else begin : g_part
    assign w_acc_nxt = {w_sum, r_acc[W-1:K]};
  end

  assign w_last = (r_cnt == c_LAST);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cin   <= 1'b0;
      r_cnt   <= '0;
      r_z     <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= x;
            r_b     <= y ^ {W{sub == OP_SUB}};
            r_cin   <= (sub == OP_SUB);
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= r_a >> K;
          r_b   <= r_b >> K;
          r_acc <= w_acc_nxt;
          r_cin <= w_c[K];
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= DONE;
            r_z     <= w_acc_nxt;
            r_carry <= w_c[K];
            // w_c[K-1] is the carry into bit W-1 (r_cin when K = 1)
            r_ovf   <= w_c[K] ^ w_c[K-1];
            r_zero  <= ~|w_acc_nxt;
            r_neg   <= w_acc_nxt[W-1];
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready = (r_state == IDLE);
  assign done  = (r_state == DONE);
  assign z     = r_z;
  assign carry = r_carry;
  assign ovf   = r_ovf;
  assign zero  = r_zero;
  assign neg   = r_neg;

endmodule : serial_add_sub

`default_nettype wire

// File: tb/tb_serial_add_sub.sv
// ============================================================================
// Module      : tb_serial_add_sub
// Description : Self-checking bench for serial_add_sub (W8/K2, W3/K1, W3/K3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_sub;

  typedef struct {
    int z;
    int carry;
    int ovf;
    int zero;
    int neg;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic [2:0] start = '0;
  logic       sub = 1'b0;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  int         sel = 0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  logic       o0_ready, o0_done, o0_carry, o0_ovf, o0_zero, o0_neg;
  logic [7:0] o0_z;
  logic       o1_ready, o1_done, o1_carry, o1_ovf, o1_zero, o1_neg;
  logic [2:0] o1_z;
  logic       o2_ready, o2_done, o2_carry, o2_ovf, o2_zero, o2_neg;
  logic [2:0] o2_z;

  logic       m_ready, m_done, m_carry, m_ovf, m_zero, m_neg;
  logic [7:0] m_z;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_sub #(.W(8), .K(2)) u_dut0 (
    .clk(clk), .rst_b(rst_b), .start(start[0]), .sub(sub), .x(x), .y(y),
    .ready(o0_ready), .done(o0_done), .z(o0_z), .carry(o0_carry),
    .ovf(o0_ovf), .zero(o0_zero), .neg(o0_neg)
  );

  serial_add_sub #(.W(3), .K(1)) u_dut1 (
    .clk(clk), .rst_b(rst_b), .start(start[1]), .sub(sub), .x(x[2:0]), .y(y[2:0]),
    .ready(o1_ready), .done(o1_done), .z(o1_z), .carry(o1_carry),
    .ovf(o1_ovf), .zero(o1_zero), .neg(o1_neg)
  );

  serial_add_sub #(.W(3), .K(3)) u_dut2 (
    .clk(clk), .rst_b(rst_b), .start(start[2]), .sub(sub), .x(x[2:0]), .y(y[2:0]),
    .ready(o2_ready), .done(o2_done), .z(o2_z), .carry(o2_carry),
    .ovf(o2_ovf), .zero(o2_zero), .neg(o2_neg)
  );

  always_comb begin
    {m_ready, m_done, m_carry, m_ovf, m_zero, m_neg} = '0;
    m_z = '0;
    case (sel)
      1: begin
        {m_ready, m_done, m_carry, m_ovf, m_zero, m_neg} =
          {o1_ready, o1_done, o1_carry, o1_ovf, o1_zero, o1_neg};
        m_z = {5'd0, o1_z};
      end
      2: begin
        {m_ready, m_done, m_carry, m_ovf, m_zero, m_neg} =
          {o2_ready, o2_done, o2_carry, o2_ovf, o2_zero, o2_neg};
        m_z = {5'd0, o2_z};
      end
      default: begin
        {m_ready, m_done, m_carry, m_ovf, m_zero, m_neg} =
          {o0_ready, o0_done, o0_carry, o0_ovf, o0_zero, o0_neg};
        m_z = o0_z;
      end
    endcase
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed views
  function automatic res_t ref_op(input int w, input int sb, input int a, input int b);
    res_t r;
    int mask, xv, yv, s, sx, sy, ss;
    mask = (1 << w) - 1;
    xv = a & mask;
    yv = b & mask;
    sx = (xv >= (1 << (w - 1))) ? xv - (1 << w) : xv;
    sy = (yv >= (1 << (w - 1))) ? yv - (1 << w) : yv;
    if (sb != 0) begin
      s = xv - yv;
      r.carry = (xv >= yv) ? 1 : 0;
      ss = sx - sy;
    end else begin
      s = xv + yv;
      r.carry = (s > mask) ? 1 : 0;
      ss = sx + sy;
    end
    r.z = s & mask;
    r.ovf = (ss > (1 << (w - 1)) - 1 || ss < -(1 << (w - 1))) ? 1 : 0;
    r.zero = (r.z == 0) ? 1 : 0;
    r.neg = (r.z >> (w - 1)) & 1;
    return r;
  endfunction

  task automatic do_op(input int s, input int sb, input int a, input int b,
                       output res_t r, output int lat);
    sel = s;
    @(negedge clk);
    sub = sb[0];
    x = a[7:0];
    y = b[7:0];
    start[s] = 1'b1;
    @(posedge clk);
    #1;
    start = '0;
    lat = 0;
    while (!m_done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r.z = int'(m_z);
    r.carry = int'(m_carry);
    r.ovf = int'(m_ovf);
    r.zero = int'(m_zero);
    r.neg = int'(m_neg);
    @(posedge clk);
    #1;
  endtask

  task automatic check_op(input string pfx, input int s, input int w, input int n,
                          input int sb, input int a, input int b);
    res_t got, exp;
    int lat;
    do_op(s, sb, a, b, got, lat);
    exp = ref_op(w, sb, a, b);
    check($sformatf("%s_z(%0d,%0d,%0d)", pfx, sb, a, b), got.z, exp.z);
    check($sformatf("%s_carry(%0d,%0d,%0d)", pfx, sb, a, b), got.carry, exp.carry);
    check($sformatf("%s_ovf(%0d,%0d,%0d)", pfx, sb, a, b), got.ovf, exp.ovf);
    check($sformatf("%s_zero(%0d,%0d,%0d)", pfx, sb, a, b), got.zero, exp.zero);
    check($sformatf("%s_neg(%0d,%0d,%0d)", pfx, sb, a, b), got.neg, exp.neg);
    check($sformatf("%s_latency_cycles", pfx), lat + 1, n + 1);
  endtask

  initial begin
    int t[3];
    int nd, wt;
    bit saw;

    repeat (3) @(posedge clk);
    #1;
    sel = 0;
    check("rst_ready", int'(m_ready), 1);
    check("rst_done", int'(m_done), 0);
    check("rst_z", int'(m_z), 0);
    check("rst_flags", int'({m_carry, m_ovf, m_zero, m_neg}), 0);
    @(negedge clk);
    rst_b = 1'b1;

    // Directed W=8 K=2 cases: overflow, carry/zero, borrow
    check_op("ovf127p1", 0, 8, 4, 0, 127, 1);
    check_op("c200p56", 0, 8, 4, 0, 200, 56);
    check_op("s5m7", 0, 8, 4, 1, 5, 7);
    check_op("s3m3", 0, 8, 4, 1, 3, 3);
    check_op("ovf127p1b", 0, 8, 4, 0, 127, 1);

    // Reset mid-RUN aborts with no done pulse
    sel = 0;
    @(negedge clk);
    sub = 1'b0; x = 8'd100; y = 8'd27; start[0] = 1'b1;
    @(posedge clk);
    #1;
    start = '0;
    repeat (2) @(posedge clk);
    #3;
    rst_b = 1'b0;
    #1;
    check("abort_ready", int'(m_ready), 1);
    check("abort_done", int'(m_done), 0);
    check("abort_z", int'(m_z), 0);
    check("abort_flags", int'({m_carry, m_ovf, m_zero, m_neg}), 0);
    @(negedge clk);
    rst_b = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (m_done) saw = 1'b1;
    end
    check("abort_no_done", int'(saw), 0);

    // start held high: one operation every N+2 cycles
    @(negedge clk);
    sub = 1'b0; x = 8'd10; y = 8'd20; start[0] = 1'b1;
    nd = 0;
    for (int i = 0; i < 40 && nd < 3; i++) begin
      @(posedge clk);
      #1;
      if (m_done) begin
        t[nd] = cyc;
        nd++;
      end
    end
    check("held_done_count", nd, 3);
    if (nd == 3) begin
      check("held_period0", t[1] - t[0], 6);
      check("held_period1", t[2] - t[1], 6);
    end
    check("held_z", int'(m_z), 30);
    @(negedge clk);
    start = '0;
    repeat (8) @(posedge clk);
    #1;

    // start during RUN is ignored; z holds the previous result during RUN
    @(negedge clk);
    sub = 1'b0; x = 8'd50; y = 8'd60; start[0] = 1'b1;
    @(posedge clk);
    #1;
    start = '0;
    @(posedge clk);
    #1;
    check("run_ready", int'(m_ready), 0);
    check("run_hold_z", int'(m_z), 30);
    @(negedge clk);
    sub = 1'b1; x = 8'd1; y = 8'd2; start[0] = 1'b1;
    @(posedge clk);
    #1;
    start = '0;
    wt = 0;
    while (!m_done && wt < 40) begin
      @(posedge clk);
      #1;
      wt++;
    end
    check("ign_done_seen", int'(m_done), 1);
    check("ign_z", int'(m_z), 110);
    saw = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (!m_ready) saw = 1'b1;
    end
    check("ign_not_queued", int'(saw), 0);
    check("idle_hold_z", int'(m_z), 110);

    // Randomized W=8 K=2
    repeat (40) begin
      check_op("rnd8", 0, 8, 4, int'($urandom_range(1, 0)),
               int'($urandom_range(255, 0)), int'($urandom_range(255, 0)));
    end

    // Exhaustive W=3 with K=1 and K=3
    for (int sb = 0; sb < 2; sb++)
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++) begin
          check_op("w3k1", 1, 3, 3, sb, a, b);
          check_op("w3k3", 2, 3, 1, sb, a, b);
        end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule : tb_serial_add_sub

`default_nettype wire
